hex_scan_driver: RTL
====================

# hex_scan_driver

Parametrised multiplexed hex-display driver for the calculator's seven-segment output path. It captures a multi-digit hex word into a shadow register on `load`, so the display does not tear while the stack/queue datapath changes. It then scans one nibble per digit slot, either automatically from an internal refresh prescaler or manually from an edge-detected `rotate` pulse. It also provides optional leading-zero blanking and a one-hot digit-anode output. It replaces the fixed 8-digit nibble selector and sits between the calculator result register and the seven-segment decoder.

## Interface
Parameters:
- `DIGITS`, default 8: number of hex digits (2..16, need not be a power of two).
- `SCAN_DIV`, default 100000: clock cycles per digit in auto mode (≥2).
- `SEL_W`, default `$clog2(DIGITS)`: width of the digit index.

Ports:
- `clk`  in  1: system clock, all state updates on the rising edge.
- `rst`  in  1: one clock; reset is asynchronous and active-high.
- `in`  in  4*DIGITS: value to display; nibble i is `in[4i+3:4i]`, digit 0 is the rightmost.
- `load`  in  1: capture `in` into the shadow register.
- `auto`  in  1: 1 = prescaler-driven scan, 0 = manual scan via `rotate`.
- `rotate`  in  1: manual step; acts on its rising edge only.
- `blank_lz`  in  1: enable leading-zero blanking.
- `hexVal`  out  4: nibble of the currently scanned digit (registered).
- `digit_sel`  out  SEL_W: index of the digit shown on `hexVal`/`an` (registered).
- `an`  out  DIGITS: active-low one-hot anode; all ones when the digit is blanked (registered).
- `blank`  out  1: 1 when the current digit is suppressed (registered).

## Operation
- State:
  - shadow `snap[4*DIGITS-1:0]`
  - scan index `sel` (0..DIGITS-1)
  - prescaler `pcnt` (0..SCAN_DIV-1)
  - `rot_q` (previous `rotate`)
- Load: when `load`=1 at an edge, `snap <= in`. While `load`=0, `snap` holds. All display outputs derive from `snap`, never directly from `in`.
- Step generation:
  - Auto mode (`auto`=1):
    - `pcnt` increments every cycle.
    - When `pcnt` = SCAN_DIV-1, `pcnt` returns to 0 and a step fires in that cycle.
    - `rotate` is ignored, but `rot_q` still tracks it.
  - Manual mode (`auto`=0):
    - `pcnt` is held at 0.
    - A step fires when `rotate`=1 and `rot_q`=0.
    - A held-high `rotate` produces exactly one step.
- Step: `sel <= (sel == DIGITS-1) ? 0 : sel+1`. Wrap uses DIGITS, not 2^SEL_W, so unused index values never occur.
- Switching `auto` from 1 to 0 clears `pcnt` on the next edge. Switching from 0 to 1 starts counting from 0, so the first auto step comes SCAN_DIV cycles later.
- Blanking: digit i (i ≥ 1) is blanked iff `blank_lz`=1 and nibbles i..DIGITS-1 of `snap` are all zero. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Output register, updated every edge from the current (pre-edge) `sel` and `snap`:
  - `hexVal <= snap nibble[sel]`
  - `digit_sel <= sel`
  - `blank <= blanked(sel)`
  - `an <= blank ? all ones : ~(1 << sel)`
- `hexVal` carries the real nibble (0) even when the digit is blanked; downstream gates on `blank`/`an`.

## Timing
- Reset (async, immediate):
  - `snap`=0, `sel`=0, `pcnt`=0, `rot_q`=0
  - `hexVal`=0, `digit_sel`=0, `blank`=1, `an`=all ones
- First valid outputs appear after the first rising edge with `rst` low. That first edge shows digit 0, `an` = ~1, `blank`=0.
- Latency:
  - A step at edge k changes `sel` at k; outputs show the new digit at edge k+1.
  - A `load` at edge k updates `snap` at k; outputs reflect the new data at edge k+1.
- `load` and a step in the same cycle: both take effect at the same edge. At the next edge, outputs show the new `sel` with the new `snap`.
- Auto period: exactly SCAN_DIV cycles per digit; a full frame is DIGITS*SCAN_DIV cycles.
- Reset asserted mid-scan returns immediately to the reset values above. After release, `pcnt` restarts at 0 and `sel` at 0.
- `rotate` is synchronous to `clk`; synchronisation and debounce happen upstream.

## Test plan
- Reset/release, DIGITS=8, `in`=0x89ABCDEF, `load` pulsed once, `auto`=0 → after reset `an`=0xFF, `blank`=1. One edge after load, `hexVal`=0xF, `digit_sel`=0, `an`=0xFE.
- Manual scan: 8 single-cycle `rotate` pulses → `hexVal` sequence E,D,C,B,A,9,8,F with `an` walking 0xFD…0x7F then back to 0xFE. `rotate` held high 10 cycles → exactly one step.
- Auto scan, SCAN_DIV=4, DIGITS=5 → `digit_sel` advances every 4 cycles, sequence 0,1,2,3,4,0. Toggling `auto` to 0 freezes `sel`; returning to 1 gives the next step 4 cycles later.
- Blanking: `snap`=0x000000A0, `blank_lz`=1 → digits 0,1 unblanked (`hexVal` 0,A); digits 2..7 give `blank`=1, `an`=0xFF. `snap`=0 → only digit 0 is lit, showing 0. `blank_lz`=0 → all digits lit.
- Shadowing: change `in` without `load` → outputs unchanged. `load` coincident with a step → new digit and new data appear together one edge later.
- Reset mid-scan, auto, `sel`=5, `pcnt`=2 → immediate reset values. After release, the first step occurs at SCAN_DIV cycles and lands on `sel`=1.

Source files
------------

// File: rtl/hex_scan_driver.sv
// hex_scan_driver
//
// Multiplexed hex-display driver. A multi-digit hex word is captured into a
// shadow register on `load` so the display never tears while the source value
// changes. One nibble per digit slot is then scanned out, stepping either from
// an internal refresh prescaler (auto mode) or from the rising edge of
// `rotate` (manual mode). Optional leading-zero blanking suppresses digits
// above the most significant non-zero nibble. Digit 0 is never blanked.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   in        - value to display, nibble i = in[4i+3:4i], digit 0 rightmost
//   load      - capture `in` into the shadow register
//   auto      - 1: prescaler-driven scan, 0: manual scan via `rotate`
//   rotate    - manual step, acts on its rising edge only
//   blank_lz  - enable leading-zero blanking
//   hexVal    - nibble of the scanned digit (registered)
//   digit_sel - index of the scanned digit (registered)
//   an        - active-low one-hot anode, all ones when blanked (registered)
//   blank     - current digit is suppressed (registered)

module hex_scan_driver #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned SEL_W    = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   in,
  input  logic                  load,
  input  logic                  auto,
  input  logic                  rotate,
  input  logic                  blank_lz,
  output logic [3:0]            hexVal,
  output logic [SEL_W-1:0]      digit_sel,
  output logic [DIGITS-1:0]     an,
  output logic                  blank
);

  localparam int unsigned PcntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PcntW-1:0] PcntMax = PcntW'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SelMax  = SEL_W'(DIGITS - 1);

  // State
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [PcntW-1:0]    pcnt_q, pcnt_d;
  logic                rot_q;

  logic                step;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   upper_zero;
  logic [DIGITS-1:0]   onehot;
  logic                cur_blank;
  logic [DIGITS-1:0]   cur_an;

  // Step generation and next-state
  always_comb begin
    step   = auto ? (pcnt_q == PcntMax) : (rotate & ~rot_q);

    // Prescaler only runs in auto mode; leaving auto mode clears it so the
    // next auto step is a full period away.
    pcnt_d = '0;
    if (auto && (pcnt_q != PcntMax)) begin
      pcnt_d = pcnt_q + 1'b1;
    end

    // Wrap at DIGITS-1 so unused index codes never appear.
    sel_d = sel_q;
    if (step) begin
      sel_d = (sel_q == SelMax) ? '0 : sel_q + 1'b1;
    end

    snap_d = load ? in : snap_q;
  end

  // Digit decode from the shadow register
  always_comb begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib[i] = snap_q[4*i +: 4];
    end
  end

  // upper_zero[i]: nibbles i..DIGITS-1 are all zero
  always_comb begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      logic z;
      z = 1'b1;
      for (int j = i; j < int'(DIGITS); j++) begin
        z = z & (nib[j] == 4'h0);
      end
      upper_zero[i] = z;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      onehot[i] = (sel_q == SEL_W'(i));
    end
    cur_blank = blank_lz && (sel_q != '0) && upper_zero[sel_q];
    cur_an    = cur_blank ? '1 : ~onehot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q    <= '0;
      sel_q     <= '0;
      pcnt_q    <= '0;
      rot_q     <= 1'b0;
      hexVal    <= 4'h0;
      digit_sel <= '0;
      blank     <= 1'b1;
      an        <= '1;
    end else begin
      snap_q    <= snap_d;
      sel_q     <= sel_d;
      pcnt_q    <= pcnt_d;
      rot_q     <= rotate;
      // Outputs reflect the pre-edge index and shadow value.
      hexVal    <= nib[sel_q];
      digit_sel <= sel_q;
      blank     <= cur_blank;
      an        <= cur_an;
    end
  end

endmodule
